// File: rtl/uart_pkg.sv
// Shared UART constants used by uart_rx, uart_tx and the receive FIFO.
package uart_pkg;

    localparam int UART_BYTE_W   = 8;
    localparam int RX_FIFO_DEPTH = 16;
    localparam int RX_FIFO_AW    = $clog2(RX_FIFO_DEPTH);

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, combinational read.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming byte; contents are intentionally left uninitialised.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Head entry is visible immediately so the FIFO can fall through.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer between uart_rx and the consumer, with a
// sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH,
    parameter int WIDTH = UART_BYTE_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             overflow,
    input  logic             clr_ovf
);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] head;
    logic             wr_acc;
    logic             rd_acc;
    logic             drop;

    // Accept decisions; a write into a full buffer succeeds only if the
    // head is leaving on the same edge, which frees exactly its slot.
    always_comb begin
        empty  = (count == '0);
        full   = (count == (AW+1)'(DEPTH));
        wr_acc = we && (!full || rd_en);
        rd_acc = rd_en && !empty;
        drop   = we && full && !rd_en;
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Pointers wrap naturally; count moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Stale RAM contents never leak out while the buffer is empty.
    always_comb begin
        data_out = empty ? '0 : head;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: table vectors, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             we = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             empty;
    logic             full;
    logic [AW:0]      count;
    logic             overflow;
    logic             clr_ovf = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a queue plus the sticky flag.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf = 1'b0;

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        int         e_count;
        logic [7:0] e_dout;
        logic       e_ovf;
    } vec_t;

    uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_count, input int e_dout, input int e_ovf);
        chk({tag, ".count"}, int'(count), e_count);
        chk({tag, ".empty"}, int'(empty), (e_count == 0) ? 1 : 0);
        chk({tag, ".full"}, int'(full), (e_count == DEPTH) ? 1 : 0);
        chk({tag, ".data_out"}, int'(data_out), e_dout);
        chk({tag, ".overflow"}, int'(overflow), e_ovf);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, q.size(), (q.size() == 0) ? 0 : int'(q[0]), int'(m_ovf));
    endtask

    // One clock cycle of stimulus; model advances by the same rules.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        bit m_full, m_empty, racc, wacc;
        we = w; data_in = d; rd_en = r; clr_ovf = c;
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        racc = r && !m_empty;
        wacc = w && (!m_full || r);
        if (w && m_full && !r) m_ovf = 1'b1;
        else if (c)            m_ovf = 1'b0;
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back(d);
        @(posedge clk);
        #1;
        we = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        // Table for the basic FWFT path and the empty write+read case.
        vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b0, 1'b0, 2, 8'hA5, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h3C, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'h42, 1'b1, 1'b0, 1, 8'h42, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0});

        // Reset with no traffic.
        #3;
        chk_all("reset_async", 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all("reset_idle", 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].din, vecs[i].rd, vecs[i].clr);
            chk_all($sformatf("vec%0d", i), vecs[i].e_count, int'(vecs[i].e_dout), int'(vecs[i].e_ovf));
        end

        // Fill, drop a 17th byte, drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk_all("fill16", 16, 0, 0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk_all("drop_ff", 16, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", int'(data_out), i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_all("drained", 0, 0, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_all("clr_ovf", 0, 0, 0);

        // Full with simultaneous write and read: pointer wrap, no overflow.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk_all("full_wr_rd", 16, 1, 0);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("wrap_order", int'(data_out), (i == DEPTH) ? 'h77 : i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk_all("wrap_empty", 0, 0, 0);

        // Drop and clear in the same cycle: set wins.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 'h20), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        chk_all("set_wins", 16, 'h20, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_all("clr_after", 16, 'h20, 0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset mid-stream with writes active.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 'h50), 1'b0, 1'b0);
        chk("pre_reset_count", int'(count), 5);
        we = 1'b1; data_in = 8'hAB;
        #3;
        reset = 1'b0;
        #1;
        chk_all("reset_mid", 0, 0, 0);
        @(posedge clk); #1;
        chk_all("reset_held", 0, 0, 0);
        we = 1'b0;
        reset = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk_all("post_reset_wr", 1, 'h11, 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic against the model, write-heavy then balanced.
        for (int n = 0; n < 800; n++) begin
            logic w, r, c;
            if (n < 300) begin
                w = ($urandom_range(3) != 0);
                r = ($urandom_range(3) == 0);
            end else if (n < 500) begin
                w = ($urandom_range(3) == 0);
                r = ($urandom_range(3) != 0);
            end else begin
                w = $urandom_range(1);
                r = $urandom_range(1);
            end
            c = ($urandom_range(15) == 0);
            step(w, 8'($urandom), r, c);
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
